trigsend: RTL and testbench
===========================

Name: trigsend

Overview:
- Transmit end of the trigger-word stream.
- Consumes an ordinary backpressured dti stream of payloads and produces dti words in the form {flag, payload}:
  - flag=1 carries a new value.
  - flag=0 is an invalidate word telling the downstream trigger register to drop its held value.
- Buffers input so bursts survive output stalls.
- Can automatically emit an invalidate word after a configurable idle period, so a far-end sampled register does not hold stale data indefinitely.

Parameters:
- DIN, 9: dout data width including flag bit; payload width is DIN-1 (min 2).
- DEPTH, 2: internal FIFO depth in payload words; power of two, >=2.
- TIMEOUT, 0: idle cycles after last data word before an invalidate word is emitted; 0 disables invalidate generation.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- din.data, input, DIN-1: payload.
- din.valid, input, 1: payload valid.
- din.ready, output, 1: payload accepted when valid&&ready.
- dout.data, output, DIN: {flag, payload}; flag is the MSB.
- dout.valid, output, 1: output word valid.
- dout.ready, input, 1: output word accepted when valid&&ready.

Behaviour:
- Reset (async assert, sync-safe release):
  - FIFO empty, state IDLE, idle counter 0, dout.valid=0, dout.data=0.
  - din.ready=0 while rst is high.
  - Reset mid-operation discards all buffered words; no invalidate is emitted for them.
- Input side:
  - din.ready = !full, computed from registered occupancy.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Push on din.valid&&din.ready.
- Latency: a word accepted at edge N is presented on dout from cycle N+1 if the FIFO was empty. Registered output; first-word fall-through after one cycle.
- Ordering: words leave in acceptance order with no loss and no duplication. Back-to-back pops at one word per cycle while dout.ready=1.
- dti rule: once dout.valid=1, dout.data and dout.valid stay stable until dout.ready=1. A presented invalidate word is never withdrawn or replaced by data.
- Output mux: data word {1'b1, head} has priority over starting an invalidate, unless an invalidate is already presented.
- States:
  - IDLE: no data sent since last invalidate or reset; counter held at 0.
  - ARMED: entered on every accepted data output word; counter cleared to 0 on that transfer.
    - Each cycle with FIFO empty and no output transfer, counter increments.
    - FIFO non-empty holds the counter.
    - Counter reaching TIMEOUT moves to INV_PEND.
  - INV_PEND: dout.valid=1, dout.data=0 (flag 0, payload 0); FIFO may keep filling.
    - On dout.ready, go to IDLE; any buffered data then follows on the next cycle.
- TIMEOUT=0: the state machine never leaves IDLE/ARMED toward INV_PEND; flag is always 1.
- Counter width: clog2(TIMEOUT+1); saturates, never wraps.
- Occupancy counter width: clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.

Test Plan (DIN=9, DEPTH=2, TIMEOUT=4 unless noted):
1. Push 0xA5 once, dout.ready=1 -> dout.data=0x1A5 the cycle after acceptance; 4 idle cycles later dout.data=0x000 valid for exactly one cycle; then dout.valid=0 permanently.
2. dout.ready=0, drive 0x01,0x02,0x03 -> din.ready=0 after 2 accepts, 0x03 held. Release dout.ready -> outputs 0x101,0x102,0x103 on consecutive cycles, no gaps.
3. Reach INV_PEND with dout.ready=0, then push 0x55 -> dout.data stays 0x000 until a ready cycle, then 0x155 next cycle; no second invalidate until 4 further idle cycles.
4. Words 0x10,0x11,0x12 spaced by 3 idle cycles each -> no flag-0 word appears between them; invalidate appears 4 cycles after 0x112 transfers.
5. TIMEOUT=0, push 0x7F then 100 idle cycles -> single 0x17F output; no flag-0 word ever appears.
6. Fill FIFO with 0x0A,0x0B, assert rst between clock edges -> dout.valid and din.ready drop immediately. After release, dout.valid stays 0 until a new push; no stale data and no invalidate.

Source files
------------

// File: rtl/trigsend.sv
`default_nettype none
// ============================================================================
//  Module      : trigsend
//  Description : Transmit end of the trigger-word stream. Buffers payloads
//                in a small FIFO and emits {flag, payload} words; flag=1
//                carries a value, flag=0 tells the far-end trigger register
//                to drop its held value. An invalidate word can be emitted
//                automatically after TIMEOUT idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module trigsend #(
    parameter int DIN     = 9,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DIN-2:0] din_data_i,
    input  logic           din_valid_i,
    output logic           din_ready_o,
    output logic [DIN-1:0] dout_data_o,
    output logic           dout_valid_o,
    input  logic           dout_ready_i
);

    localparam int PW = DIN - 1;
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam bit            INV_EN   = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_INV   = 2'd2
    } state_t;

    // FIFO storage and bookkeeping. The word currently presented on dout is
    // still counted in the occupancy until it is accepted downstream.
    logic [PW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]  occ_q, occ_d;

    logic [CW-1:0]  cnt_q, cnt_d;
    state_t         state_q, state_d;

    logic           dout_valid_q, dout_valid_d;
    logic [DIN-1:0] dout_data_q, dout_data_d;

    logic           push;
    logic           xfer;
    logic           pop;
    logic           avail;

    assign din_ready_o  = !rst && (occ_q != OCC_FULL);
    assign push         = din_valid_i && din_ready_o;
    assign xfer         = dout_valid_q && dout_ready_i;
    // Only an accepted data word (flag=1) leaves the FIFO; an invalidate
    // word is generated, not stored.
    assign pop          = xfer && dout_data_q[DIN-1];
    // Words already stored that remain after this cycle's pop.
    assign avail        = (occ_q > OW'(pop));

    assign dout_valid_o = dout_valid_q;
    assign dout_data_o  = dout_data_q;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        occ_d    = occ_q + OW'(push) - OW'(pop);
    end

    // Idle-timeout state machine: next state and idle counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_ARMED: begin
                if ((occ_q == '0) && !xfer && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Incoming data wins over starting an invalidate.
                if (INV_EN && (occ_q == '0) && !xfer && !push && (cnt_d == CNT_MAX)) begin
                    state_d = S_INV;
                end
            end
            S_INV: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Every accepted data word re-arms the timer.
        if (pop) begin
            state_d = S_ARMED;
            cnt_d   = '0;
        end
    end

    // Output register: hold while stalled, otherwise load invalidate,
    // buffered head, or the word arriving this cycle (fall-through).
    always_comb begin
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        if (!dout_valid_q || dout_ready_i) begin
            if (state_d == S_INV) begin
                dout_valid_d = 1'b1;
                dout_data_d  = '0;
            end else if (avail) begin
                dout_valid_d = 1'b1;
                dout_data_d  = {1'b1, mem_q[rd_ptr_d]};
            end else if (push) begin
                dout_valid_d = 1'b1;
                dout_data_d  = {1'b1, din_data_i};
            end else begin
                dout_valid_d = 1'b0;
                dout_data_d  = '0;
            end
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din_data_i;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            cnt_q        <= '0;
            state_q      <= S_IDLE;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trigsend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trigsend
//  Description : Self-checking bench for trigsend (TIMEOUT=4 and TIMEOUT=0
//                instances) with a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trigsend;

    localparam int DEPTH = 2;
    localparam int MT    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_din = '0;
    logic       a_dv  = 1'b0;
    logic       a_dr;
    logic [8:0] a_do;
    logic       a_ov;
    logic       a_or  = 1'b1;

    logic [7:0] b_din = '0;
    logic       b_dv  = 1'b0;
    logic       b_dr;
    logic [8:0] b_do;
    logic       b_ov;
    logic       b_or  = 1'b1;

    trigsend #(.DIN(9), .DEPTH(DEPTH), .TIMEOUT(MT)) u_a (
        .clk(clk), .rst(rst),
        .din_data_i(a_din), .din_valid_i(a_dv), .din_ready_o(a_dr),
        .dout_data_o(a_do), .dout_valid_o(a_ov), .dout_ready_i(a_or)
    );

    trigsend #(.DIN(9), .DEPTH(DEPTH), .TIMEOUT(0)) u_b (
        .clk(clk), .rst(rst),
        .din_data_i(b_din), .din_valid_i(b_dv), .din_ready_o(b_dr),
        .dout_data_o(b_do), .dout_valid_o(b_ov), .dout_ready_i(b_or)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer logs (word and cycle stamp) for both instances.
    logic [8:0] la_d[$];
    int         la_c[$];
    logic [8:0] lb_d[$];
    int         b_flag0 = 0;

    always @(posedge clk) begin
        if (!rst && a_ov && a_or) begin
            la_d.push_back(a_do);
            la_c.push_back(cyc);
        end
        if (!rst && b_ov && b_or) begin
            lb_d.push_back(b_do);
            if (!b_do[8]) b_flag0++;
        end
    end

    // Reference model for instance A: queue of buffered payloads (head is
    // the word being presented), an armed flag and an idle-cycle count.
    logic [7:0] mq[$];
    logic       m_valid = 1'b0;
    logic [8:0] m_data  = '0;
    bit         m_armed = 1'b0;
    int         m_idle  = 0;

    always @(posedge clk or posedge rst) begin : model
        bit acc;
        bit xf;
        if (rst) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_armed = 1'b0;
            m_idle  = 0;
        end else begin
            acc = a_dv && (mq.size() < DEPTH);
            xf  = m_valid && a_or;
            if (xf) begin
                if (m_data[8]) void'(mq.pop_front());
                m_armed = m_data[8];
                m_idle  = 0;
            end else if (m_armed && mq.size() == 0 && m_idle < MT) begin
                m_idle++;
            end
            if (acc) mq.push_back(a_din);
            if (m_valid && !xf) begin
                // stalled: word held
            end else if (mq.size() > 0) begin
                m_valid = 1'b1;
                m_data  = {1'b1, mq[0]};
            end else if (m_armed && MT > 0 && m_idle >= MT) begin
                m_valid = 1'b1;
                m_data  = '0;
                m_armed = 1'b0;
            end else begin
                m_valid = 1'b0;
                m_data  = '0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_din_ready", a_dr, (mq.size() < DEPTH));
            chk("model_dout_valid", a_ov, m_valid);
            if (m_valid) chk("model_dout_data", a_do, m_data);
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_a(input logic [7:0] d);
        int n;
        n = 0;
        a_din = d;
        a_dv  = 1'b1;
        while (!a_dr && n <= 200) begin
            @(negedge clk);
            n++;
        end
        if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL send_a_timeout actual=stalled required=accept data=%0h", d);
        end
        @(negedge clk);
        a_dv = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int n;
        n = 0;
        b_din = d;
        b_dv  = 1'b1;
        while (!b_dr && n <= 200) begin
            @(negedge clk);
            n++;
        end
        if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL send_b_timeout actual=stalled required=accept data=%0h", d);
        end
        @(negedge clk);
        b_dv = 1'b0;
    endtask

    task automatic clear_logs();
        la_d.delete();
        la_c.delete();
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_dout_valid", a_ov, 1'b0);
        chk("rst_dout_data", a_do, 9'h000);
        chk("rst_din_ready", a_dr, 1'b0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_din_ready", a_dr, 1'b1);
        chk("post_rst_dout_valid", a_ov, 1'b0);

        // 1: single word, then automatic invalidate
        clear_logs();
        a_or = 1'b1;
        send_a(8'hA5);
        chk("t1_first_word", a_do, 9'h1A5);
        chk("t1_first_valid", a_ov, 1'b1);
        repeat (20) @(negedge clk);
        chk("t1_count", la_d.size(), 2);
        if (la_d.size() == 2) begin
            chk("t1_w0", la_d[0], 9'h1A5);
            chk("t1_w1", la_d[1], 9'h000);
            chk("t1_gap", la_c[1] - la_c[0], 5);
        end
        chk("t1_quiet", a_ov, 1'b0);

        // 2: stall fills FIFO, release drains back-to-back
        clear_logs();
        a_or = 1'b0;
        fork
            begin
                send_a(8'h01);
                send_a(8'h02);
                send_a(8'h03);
            end
            begin
                repeat (4) @(negedge clk);
                chk("t2_full_ready", a_dr, 1'b0);
                chk("t2_head", a_do, 9'h101);
                chk("t2_none_out", la_d.size(), 0);
                a_or = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        chk("t2_count", la_d.size(), 3);
        if (la_d.size() == 3) begin
            chk("t2_w0", la_d[0], 9'h101);
            chk("t2_w1", la_d[1], 9'h102);
            chk("t2_w2", la_d[2], 9'h103);
            chk("t2_gap01", la_c[1] - la_c[0], 1);
            chk("t2_gap12", la_c[2] - la_c[1], 1);
        end
        repeat (10) @(negedge clk);

        // 3: invalidate held under stall, then data follows
        a_or = 1'b1;
        send_a(8'h20);
        @(negedge clk);
        a_or = 1'b0;
        clear_logs();
        repeat (6) @(negedge clk);
        chk("t3_inv_valid", a_ov, 1'b1);
        chk("t3_inv_data", a_do, 9'h000);
        send_a(8'h55);
        repeat (3) @(negedge clk);
        chk("t3_inv_held", a_do, 9'h000);
        chk("t3_inv_held_v", a_ov, 1'b1);
        a_or = 1'b1;
        repeat (12) @(negedge clk);
        chk("t3_count", la_d.size(), 3);
        if (la_d.size() == 3) begin
            chk("t3_w0", la_d[0], 9'h000);
            chk("t3_w1", la_d[1], 9'h155);
            chk("t3_w2", la_d[2], 9'h000);
            chk("t3_gap01", la_c[1] - la_c[0], 1);
            chk("t3_gap12", la_c[2] - la_c[1], 5);
        end

        // 4: words spaced by 3 idle cycles never trigger an invalidate
        clear_logs();
        send_a(8'h10);
        repeat (3) @(negedge clk);
        send_a(8'h11);
        repeat (3) @(negedge clk);
        send_a(8'h12);
        repeat (12) @(negedge clk);
        chk("t4_count", la_d.size(), 4);
        if (la_d.size() == 4) begin
            chk("t4_w0", la_d[0], 9'h110);
            chk("t4_w1", la_d[1], 9'h111);
            chk("t4_w2", la_d[2], 9'h112);
            chk("t4_w3", la_d[3], 9'h000);
            chk("t4_gap01", la_c[1] - la_c[0], 4);
            chk("t4_gap12", la_c[2] - la_c[1], 4);
            chk("t4_gap23", la_c[3] - la_c[2], 5);
        end

        // 5: TIMEOUT=0 never emits an invalidate
        send_b(8'h7F);
        repeat (100) @(negedge clk);
        chk("t5_count", lb_d.size(), 1);
        if (lb_d.size() == 1) chk("t5_w0", lb_d[0], 9'h17F);
        chk("t5_no_flag0", b_flag0, 0);
        chk("t5_quiet", b_ov, 1'b0);

        // 6: asynchronous reset discards buffered words
        clear_logs();
        a_or = 1'b0;
        send_a(8'h0A);
        send_a(8'h0B);
        chk("t6_full", a_dr, 1'b0);
        chk("t6_presented", a_ov, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", a_ov, 1'b0);
        chk("t6_rst_ready", a_dr, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        a_or = 1'b1;
        repeat (12) @(negedge clk);
        chk("t6_no_output", la_d.size(), 0);
        chk("t6_quiet", a_ov, 1'b0);

        // Operation resumes normally after reset
        send_a(8'h33);
        chk("t6_resume", a_do, 9'h133);
        repeat (3) @(negedge clk);
        chk("t6_resume_count", la_d.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
